// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module  : dmem_mmio
// Purpose : Data-side memory responder: word RAM plus an MMIO block with a
//           cycle counter, LED register and buffered byte console TX port.
// Revision: 1.0  initial release
// ============================================================================
module dmem_mmio #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  leds,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bad_access
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [31:0] c_RAM_LIMIT    = 32'(4 * RAM_WORDS);
    localparam logic [31:0] c_ADDR_CYCLE   = 32'h0000_8000;
    localparam logic [31:0] c_ADDR_LED     = 32'h0000_8004;
    localparam logic [31:0] c_ADDR_CONSOLE = 32'h0000_8008;
    localparam logic [PW:0] c_FIFO_FULL    = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] c_PTR_ONE    = PW'(1);

    logic [31:0]   ram_q [RAM_WORDS];
    logic [7:0]    fifo_q [FIFO_DEPTH];

    logic [31:0]   cycle_q, cycle_d;
    logic [7:0]    leds_q, leds_d;
    logic          bad_q, bad_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;

    logic          w_aligned;
    logic          w_hit_cycle, w_hit_led, w_hit_con, w_hit_mmio, w_hit_ram;
    logic          w_mapped;
    logic [AW-1:0] w_ram_idx;
    logic          w_full, w_empty, w_pop, w_push, w_push_ok;
    logic [31:0]   w_status;

    // MMIO decode takes priority so a large RAM never shadows the registers.
    assign w_aligned   = (addr[1:0] == 2'b00);
    assign w_hit_cycle = (addr == c_ADDR_CYCLE);
    assign w_hit_led   = (addr == c_ADDR_LED);
    assign w_hit_con   = (addr == c_ADDR_CONSOLE);
    assign w_hit_mmio  = w_hit_cycle | w_hit_led | w_hit_con;
    assign w_hit_ram   = w_aligned && (addr < c_RAM_LIMIT) && !w_hit_mmio;
    assign w_mapped    = w_hit_ram | w_hit_mmio;
    assign w_ram_idx   = addr[AW+1:2];

    assign w_full    = (count_q == c_FIFO_FULL);
    assign w_empty   = (count_q == '0);
    assign w_pop     = !w_empty && tx_ready;
    assign w_push    = memwrite && w_hit_con;
    assign w_push_ok = w_push && (!w_full || w_pop);

    assign w_status = {16'h0000, 8'(count_q), 5'b00000, ovf_q, w_empty, w_full};

    always_comb begin
        cycle_d  = (memwrite && w_hit_cycle) ? 32'h0000_0000 : cycle_q + 32'd1;
        leds_d   = (memwrite && w_hit_led) ? writedata[7:0] : leds_q;
        bad_d    = bad_q | (memwrite && !w_mapped);
        ovf_d    = ovf_q | (w_push && !w_push_ok);
        rd_ptr_d = w_pop ? rd_ptr_q + c_PTR_ONE : rd_ptr_q;
        wr_ptr_d = w_push_ok ? wr_ptr_q + c_PTR_ONE : wr_ptr_q;
        count_d  = count_q;
        case ({w_push_ok, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q  <= '0;
            leds_q   <= '0;
            bad_q    <= 1'b0;
            ovf_q    <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            cycle_q  <= cycle_d;
            leds_q   <= leds_d;
            bad_q    <= bad_d;
            ovf_q    <= ovf_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage arrays carry no reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && memwrite && w_hit_ram) begin
            ram_q[w_ram_idx] <= writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push_ok) begin
            fifo_q[wr_ptr_q] <= writedata[7:0];
        end
    end

    always_comb begin
        readdata = 32'h0000_0000;
        if (w_hit_ram) begin
            readdata = ram_q[w_ram_idx];
        end else if (w_hit_cycle) begin
            readdata = cycle_q;
        end else if (w_hit_led) begin
            readdata = {24'h000000, leds_q};
        end else if (w_hit_con) begin
            readdata = w_status;
        end
    end

    assign leds       = leds_q;
    assign tx_data    = fifo_q[rd_ptr_q];
    assign tx_valid   = !w_empty;
    assign bad_access = bad_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_mmio
// Purpose : Directed plus randomized checks of dmem_mmio against a queue/array
//           reference model.
// Revision: 1.0  initial release
// ============================================================================
module tb_dmem_mmio;

    localparam int RW = 64;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  leds;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bad_access;

    always #5 clk = ~clk;

    dmem_mmio #(.RAM_WORDS(RW), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .addr       (addr),
        .writedata  (writedata),
        .readdata   (readdata),
        .leds       (leds),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .bad_access (bad_access)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0]  m_ram [int];
    logic [31:0]  m_cycle;
    logic [7:0]   m_leds;
    byte unsigned m_q [$];
    bit           m_ovf;
    bit           m_bad;
    byte unsigned drained [$];

    function automatic bit is_mapped(input logic [31:0] a);
        if (a[1:0] != 2'b00) return 1'b0;
        return (a < RW * 4) || a == 32'h8000 || a == 32'h8004 || a == 32'h8008;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, output bit known);
        int sz;
        known = 1'b1;
        sz = m_q.size();
        if (!is_mapped(a)) return 32'h0;
        if (a == 32'h8000) return m_cycle;
        if (a == 32'h8004) return {24'h0, m_leds};
        if (a == 32'h8008)
            return {16'h0, 8'(sz), 5'h0, m_ovf, (sz == 0), (sz == FD)};
        if (m_ram.exists(int'(a >> 2))) return m_ram[int'(a >> 2)];
        known = 1'b0;
        return 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit we, input logic [31:0] a,
                              input logic [31:0] wd, input bit rdy);
        if (rst) begin
            m_cycle = 32'h0;
            m_leds  = 8'h0;
            m_q.delete();
            m_ovf   = 1'b0;
            m_bad   = 1'b0;
            return;
        end
        m_cycle = (we && a == 32'h8000) ? 32'h0 : m_cycle + 32'd1;
        if (rdy && m_q.size() != 0) drained.push_back(m_q.pop_front());
        if (we) begin
            if (!is_mapped(a)) m_bad = 1'b1;
            else if (a == 32'h8004) m_leds = wd[7:0];
            else if (a == 32'h8008) begin
                if (m_q.size() < FD) m_q.push_back(wd[7:0]);
                else m_ovf = 1'b1;
            end else if (a != 32'h8000) m_ram[int'(a >> 2)] = wd;
        end
    endtask

    // Drive one cycle: check combinational/registered outputs, then clock.
    task automatic step(input bit rst, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input bit rdy);
        logic [31:0] e;
        bit known;
        reset = rst; memwrite = we; addr = a; writedata = wd; tx_ready = rdy;
        #1;
        e = exp_read(a, known);
        if (known) chk($sformatf("readdata@%h", a), readdata, e);
        chk("leds", {24'h0, leds}, {24'h0, m_leds});
        chk("tx_valid", {31'h0, tx_valid}, {31'h0, m_q.size() != 0});
        if (m_q.size() != 0) chk("tx_data", {24'h0, tx_data}, {24'h0, m_q[0]});
        chk("bad_access", {31'h0, bad_access}, {31'h0, m_bad});
        @(posedge clk);
        model_edge(rst, we, a, wd, rdy);
        #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] wd;
        reset = 1'b1; memwrite = 1'b0; addr = 32'h0; writedata = 32'h0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        model_edge(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;

        // Reset state and cycle counter
        step(1'b1, 1'b0, 32'h8008, 32'h0, 1'b0);
        chk("status_reset", readdata, 32'h0000_0002);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h8000, 32'h0, 1'b0);
        reset = 1'b0; addr = 32'h8000; #1;
        chk("cycle_after_5", readdata, 32'd5);
        step(1'b0, 1'b1, 32'h8000, 32'h1234_5678, 1'b0);
        addr = 32'h8000; memwrite = 1'b0; #1;
        chk("cycle_cleared", readdata, 32'd0);

        // Counter wrap via preload
        force dut.cycle_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_q;
        m_cycle = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h8000, 32'h0, 1'b0);
        chk("cycle_wrapped", readdata, 32'd1);

        // RAM write, read-back and same-cycle old value
        step(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        step(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h10, 32'h1234_5678, 1'b0);
        step(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);

        // Fill, overflow, drain in order
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h8008, 32'h41 + i, 1'b0);
        step(1'b0, 1'b0, 32'h8008, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h8008, 32'h58, 1'b0);
        addr = 32'h8008; memwrite = 1'b0; #1;
        chk("status_ovf", readdata, 32'h0000_0405);
        drained.delete();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h8008, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h8008, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) chk("drain_order", {24'h0, drained[i]}, 32'h41 + i);

        // Push into full FIFO while popping
        step(1'b1, 1'b0, 32'h8008, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h8008, 32'h41 + i, 1'b0);
        drained.delete();
        step(1'b0, 1'b1, 32'h8008, 32'h45, 1'b1);
        addr = 32'h8008; memwrite = 1'b0; tx_ready = 1'b0; #1;
        chk("status_push_pop_full", readdata, 32'h0000_0401);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h8008, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) chk("drain_with_E", {24'h0, drained[i]}, 32'h41 + i);

        // LED register and bad accesses
        step(1'b0, 1'b1, 32'h4, 32'hCAFE_F00D, 1'b0);
        step(1'b0, 1'b1, 32'h8004, 32'h0000_01FF, 1'b0);
        step(1'b0, 1'b0, 32'h8004, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h9000, 32'h1111_1111, 1'b0);
        step(1'b0, 1'b1, 32'h0006, 32'h2222_2222, 1'b0);
        step(1'b0, 1'b0, 32'h4, 32'h0, 1'b0);
        chk("led_kept", {24'h0, leds}, 32'hFF);
        chk("bad_set", {31'h0, bad_access}, 32'h1);
        chk("ram1_kept", readdata, 32'hCAFE_F00D);
        step(1'b0, 1'b0, 32'h9000, 32'h0, 1'b0);

        // Reset mid-drain with concurrent LED write
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h8008, 32'h61 + i, 1'b0);
        step(1'b1, 1'b1, 32'h8004, 32'h0000_0055, 1'b1);
        reset = 1'b0; memwrite = 1'b0; addr = 32'h8000; #1;
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_leds", {24'h0, leds}, 32'h0);
        chk("rst_cycle", readdata, 32'h0);
        chk("rst_bad", {31'h0, bad_access}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            wd = $urandom;
            case ($urandom_range(0, 6))
                0, 1:    a = 32'($urandom_range(0, RW - 1)) << 2;
                2:       a = (32'($urandom_range(0, RW - 1)) << 2) | 32'($urandom_range(1, 3));
                3:       a = ($urandom_range(0, 15) == 0) ? 32'h8000 : 32'h8004;
                4, 5:    a = 32'h8008;
                default: a = 32'h9000 + (32'($urandom_range(0, 255)) << 2);
            endcase
            step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, a, wd,
                 $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
